// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the gray_monitor block: FSM state encoding and Gray decode.
package gray_mon_pkg;

    localparam int STATE_W    = 2;
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    // Zero-extended inputs decode correctly because the unused upper bits are 0.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational W-bit Gray-to-binary decoder.
module gray_to_bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);
    import gray_mon_pkg::*;

    assign bin_o = W'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_monitor.sv
// Observer for an upstream Gray counter: decodes samples, checks +1 steps, counts wraps.
// Optional build macro GRAY_MON_ERRCNT_EN adds the saturating Err_Cnt output.
module gray_monitor #(
    parameter int W  = 3,
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Sample_En,
    input  logic [W-1:0]  Gray_In,
    input  logic          Ovf_In,
    input  logic          Clear,
    output logic [W-1:0]  Bin_Out,
    output logic          Bin_Valid,
    output logic          Step_Err,
    output logic          Err_Sticky,
    output logic [CW-1:0] Wrap_Cnt,
`ifdef GRAY_MON_ERRCNT_EN
    output logic [CW-1:0] Err_Cnt,
`endif
    output logic          Ovf_Seen
);
    import gray_mon_pkg::*;

    state_e        state_q;
    logic [W-1:0]  prev_gray_q;
    logic [W-1:0]  bin_q;
    logic          bin_valid_q;
    logic          step_err_q;
    logic          err_sticky_q;
    logic [CW-1:0] wrap_cnt_q;
    logic [CW-1:0] wrap_cnt_d;
    logic          ovf_seen_q;

    logic [W-1:0]  dec_in;
    logic [W-1:0]  prev_bin;
    logic [W-1:0]  prev_inc;
    logic [W-1:0]  diff;
    logic          step_hold;
    logic          step_one;
    logic          step_fwd;
    logic          at_top;

    gray_to_bin #(.W(W)) u_dec_in   (.gray_i(Gray_In),     .bin_o(dec_in));
    gray_to_bin #(.W(W)) u_dec_prev (.gray_i(prev_gray_q), .bin_o(prev_bin));

    // A power-of-two diff means exactly one Gray bit toggled.
    assign diff       = Gray_In ^ prev_gray_q;
    assign step_hold  = (diff == '0);
    assign step_one   = !step_hold && ((diff & (diff - W'(1))) == '0);
    assign prev_inc   = prev_bin + W'(1);
    assign step_fwd   = step_one && (dec_in == prev_inc);
    assign at_top     = (prev_bin == {W{1'b1}});
    assign wrap_cnt_d = (wrap_cnt_q == {CW{1'b1}}) ? wrap_cnt_q : wrap_cnt_q + CW'(1);

`ifdef GRAY_MON_ERRCNT_EN
    logic [CW-1:0] err_cnt_q;
    logic [CW-1:0] err_cnt_d;
    assign err_cnt_d = (err_cnt_q == {CW{1'b1}}) ? err_cnt_q : err_cnt_q + CW'(1);
    assign Err_Cnt   = err_cnt_q;

    // Err_Cnt survives Clear; only reset zeroes it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            err_cnt_q <= '0;
        end else if (!Clear && Sample_En && state_q == ST_TRACK && !step_hold && !step_fwd) begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values;
    // reset is synchronous and checked first so it overrides Clear and Sample_En.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            prev_gray_q  <= '0;
            bin_q        <= '0;
            bin_valid_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_cnt_q   <= '0;
            ovf_seen_q   <= 1'b0;
        end else begin
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            if (Clear) begin
                state_q      <= ST_IDLE;
                err_sticky_q <= 1'b0;
                wrap_cnt_q   <= '0;
                ovf_seen_q   <= 1'b0;
            end else begin
                if (Sample_En) begin
                    bin_q       <= dec_in;
                    bin_valid_q <= 1'b1;
                    prev_gray_q <= Gray_In;
                    if (Ovf_In) ovf_seen_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (Sample_En) state_q <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (Sample_En && !step_hold) begin
                            if (step_fwd) begin
                                if (at_top) wrap_cnt_q <= wrap_cnt_d;
                            end else begin
                                step_err_q   <= 1'b1;
                                err_sticky_q <= 1'b1;
                                state_q      <= ST_FAULT;
                            end
                        end
                    end
                    ST_FAULT: state_q <= ST_FAULT;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign Bin_Out    = bin_q;
    assign Bin_Valid  = bin_valid_q;
    assign Step_Err   = step_err_q;
    assign Err_Sticky = err_sticky_q;
    assign Wrap_Cnt   = wrap_cnt_q;
    assign Ovf_Seen   = ovf_seen_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor (W=3, CW=2): directed scenarios then random samples vs a reference model.
module tb_gray_monitor;

    localparam int W    = 3;
    localparam int CW   = 2;
    localparam int MODW = 1 << W;
    localparam int SAT  = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Sample_En;
    logic [W-1:0]  Gray_In;
    logic          Ovf_In;
    logic          Clear;
    logic [W-1:0]  Bin_Out;
    logic          Bin_Valid;
    logic          Step_Err;
    logic          Err_Sticky;
    logic [CW-1:0] Wrap_Cnt;
    logic          Ovf_Seen;
`ifdef GRAY_MON_ERRCNT_EN
    logic [CW-1:0] Err_Cnt;
`endif

    gray_monitor #(.W(W), .CW(CW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Sample_En  (Sample_En),
        .Gray_In    (Gray_In),
        .Ovf_In     (Ovf_In),
        .Clear      (Clear),
        .Bin_Out    (Bin_Out),
        .Bin_Valid  (Bin_Valid),
        .Step_Err   (Step_Err),
        .Err_Sticky (Err_Sticky),
        .Wrap_Cnt   (Wrap_Cnt),
`ifdef GRAY_MON_ERRCNT_EN
        .Err_Cnt    (Err_Cnt),
`endif
        .Ovf_Seen   (Ovf_Seen)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: binary-valued view of the monitor.
    typedef enum {M_IDLE, M_TRACK, M_FAULT} mode_e;
    mode_e m_mode = M_IDLE;
    int m_prev = 0, m_bin = 0, m_valid = 0, m_err = 0;
    int m_sticky = 0, m_wrap = 0, m_ovf = 0, m_errcnt = 0;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by searching for the binary value whose Gray code matches.
    function automatic int from_gray(input int g);
        for (int b = 0; b < MODW; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst_n, input logic se, input int g,
                              input logic ovf, input logic clr);
        int b;
        m_valid = 0;
        m_err   = 0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_prev = 0; m_bin = 0; m_sticky = 0;
            m_wrap = 0; m_ovf = 0; m_errcnt = 0;
        end else if (clr) begin
            m_mode = M_IDLE; m_sticky = 0; m_wrap = 0; m_ovf = 0;
        end else if (se) begin
            b       = from_gray(g);
            m_valid = 1;
            m_bin   = b;
            if (ovf) m_ovf = 1;
            if (m_mode == M_IDLE) begin
                m_mode = M_TRACK;
            end else if (m_mode == M_TRACK && b != m_prev) begin
                if (b == (m_prev + 1) % MODW) begin
                    if (m_prev == MODW - 1 && m_wrap < SAT) m_wrap++;
                end else begin
                    m_err = 1; m_sticky = 1; m_mode = M_FAULT;
                    if (m_errcnt < SAT) m_errcnt++;
                end
            end
            m_prev = b;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input string lbl, input logic rst_n, input logic se, input int g,
                         input logic ovf, input logic clr);
        Reset_n   = rst_n;
        Sample_En = se;
        Gray_In   = g[W-1:0];
        Ovf_In    = ovf;
        Clear     = clr;
        @(posedge Clk);
        #1;
        model_step(rst_n, se, g, ovf, clr);
        check({lbl, ".bin"},    32'(Bin_Out),    m_bin);
        check({lbl, ".valid"},  32'(Bin_Valid),  m_valid);
        check({lbl, ".err"},    32'(Step_Err),   m_err);
        check({lbl, ".sticky"}, 32'(Err_Sticky), m_sticky);
        check({lbl, ".wrap"},   32'(Wrap_Cnt),   m_wrap);
        check({lbl, ".ovf"},    32'(Ovf_Seen),   m_ovf);
`ifdef GRAY_MON_ERRCNT_EN
        check({lbl, ".errcnt"}, 32'(Err_Cnt),    m_errcnt);
`endif
    endtask

    initial begin
        int t1_gray [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        int r;
        int g;

        apply("reset0", 0, 0, 0, 0, 0);
        apply("reset1", 0, 1, 5, 1, 1);
        check("reset.bin", 32'(Bin_Out), 0);

        // 1: one full legal cycle with a wrap
        for (int i = 0; i < 9; i++) begin
            apply("t1", 1, 1, t1_gray[i], 0, 0);
            check("t1.bin_abs", 32'(Bin_Out), i % MODW);
        end
        check("t1.wrap_abs", 32'(Wrap_Cnt), 1);

        // 2: two-bit jump from 001 to 010
        apply("t2.clr", 1, 0, 0, 0, 1);
        apply("t2.s1",  1, 1, 1, 0, 0);
        apply("t2.s2",  1, 1, 2, 0, 0);
        check("t2.err_abs",    32'(Step_Err),   1);
        check("t2.sticky_abs", 32'(Err_Sticky), 1);
        check("t2.bin_abs",    32'(Bin_Out),    3);
        apply("t2.idle", 1, 0, 0, 0, 0);
        check("t2.pulse_abs", 32'(Step_Err), 0);

        // 3: backward step 011 -> 001, then Clear
        apply("t3.clr", 1, 0, 0, 0, 1);
        apply("t3.s1",  1, 1, 3, 0, 0);
        apply("t3.s2",  1, 1, 1, 0, 0);
        check("t3.err_abs", 32'(Step_Err), 1);
        apply("t3.clr2", 1, 0, 0, 0, 1);
        check("t3.sticky_abs", 32'(Err_Sticky), 0);

        // 4: repeated sample holds
        apply("t4.s1", 1, 1, 3, 0, 0);
        apply("t4.s2", 1, 1, 3, 0, 0);
        check("t4.valid_abs", 32'(Bin_Valid), 1);
        check("t4.bin_abs",   32'(Bin_Out),   2);
        check("t4.err_abs",   32'(Step_Err),  0);

        // 5: five wraps saturate the counter; overflow flag is sticky until Clear
        apply("t5.clr", 1, 0, 0, 0, 1);
        apply("t5.s0",  1, 1, 0, 0, 0);
        for (int k = 1; k <= 5 * MODW; k++) apply("t5.run", 1, 1, to_gray(k % MODW), 0, 0);
        check("t5.wrap_abs", 32'(Wrap_Cnt), 3);
        apply("t5.ovf",  1, 1, to_gray(1), 1, 0);
        apply("t5.hold", 1, 0, 0, 0, 0);
        check("t5.ovf_abs", 32'(Ovf_Seen), 1);
        apply("t5.clr2", 1, 0, 0, 0, 1);
        check("t5.ovfclr_abs", 32'(Ovf_Seen), 0);

        // 6: Clear beats a same-cycle sample; reset mid-TRACK
        apply("t6.s0",  1, 1, 0, 0, 0);
        apply("t6.cs",  1, 1, 1, 1, 1);
        check("t6.valid_abs", 32'(Bin_Valid), 0);
        apply("t6.s1",  1, 1, 5, 0, 0);
        apply("t6.s2",  1, 1, 4, 0, 0);
        apply("t6.rst", 0, 0, 0, 0, 0);
        check("t6.bin_abs", 32'(Bin_Out), 0);

        // Random phase: mostly legal steps, some holds, jumps, clears and resets
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      g = to_gray((m_prev + 1) % MODW);
            else if (r < 8) g = to_gray(m_prev);
            else            g = $urandom_range(0, MODW - 1);
            apply("rnd",
                  ($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) != 0),
                  g,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
